// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access stage.
// Covers the datapath width, the access FSM states and the RV32I load/store size codes.
package all_pkgs;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } mem_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size comes from funct3[1:0]: 00 byte, 01 half, anything else a word.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = addr_lo[0];
            default: is_misaligned = |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_aligner.sv
// Picks the addressed byte/half/word out of a memory read word and
// sign- or zero-extends it according to the load's funct3.
module load_aligner
    import all_pkgs::*;
(
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       addr,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] mem_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[8*addr +: 8];
    assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        case (funct3)
            F3_LB:   mem_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  mem_data = {24'd0, byte_sel};
            F3_LH:   mem_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  mem_data = {16'd0, half_sel};
            default: mem_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one data-memory request at a time,
// stalls the pipeline while it is outstanding, and aligns store/load data.
module mem_access
    import all_pkgs::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_mem_rd_en,
    input  logic             ex_mem_wr_en,
    input  logic [2:0]       ex_funct3,
    input  logic [WIDTH-1:0] ex_alu_result,
    input  logic [WIDTH-1:0] ex_rs2_data,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_wr_en,
    input  logic             ex_mem_to_reg,
    input  logic [1:0]       ex_wb_sel,
    output logic             dmem_req_valid,
    input  logic             dmem_req_ready,
    output logic [WIDTH-1:0] dmem_addr,
    output logic             dmem_we,
    output logic [3:0]       dmem_wstrb,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_rsp_valid,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             mem_stall,
    output logic             misalign_exc,
    output logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] alu_result,
    output logic [4:0]       rd,
    output logic             mem_to_reg,
    output logic             reg_wr_en,
    output logic [1:0]       wb_sel
);

    mem_state_t state_q, state_d;

    logic [WIDTH-1:0] addr_q, wdata_q, rdata_q, ext_data;
    logic [3:0]       wstrb_q;
    logic [2:0]       funct3_q;
    logic [4:0]       rd_q;
    logic [1:0]       wb_sel_q;
    logic             we_q, load_q, reg_wr_en_q, mem_to_reg_q;

    logic             is_mem, misaligned, start;
    logic [3:0]       st_wstrb;
    logic [WIDTH-1:0] st_wdata;
    logic             req_valid, stall, exc;

    assign is_mem     = ex_valid & (ex_mem_rd_en | ex_mem_wr_en);
    assign misaligned = is_mem & is_misaligned(ex_funct3, ex_alu_result[1:0]);
    assign start      = is_mem & ~misaligned;

    // Store lanes: narrow data is replicated so the strobe alone selects the bytes.
    always_comb begin
        case (ex_funct3[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << ex_alu_result[1:0];
                st_wdata = {4{ex_rs2_data[7:0]}};
            end
            2'b01: begin
                st_wstrb = 4'b0011 << {ex_alu_result[1], 1'b0};
                st_wdata = {2{ex_rs2_data[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = ex_rs2_data;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            funct3_q     <= '0;
            we_q         <= 1'b0;
            load_q       <= 1'b0;
            rd_q         <= '0;
            reg_wr_en_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            wb_sel_q     <= '0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                addr_q       <= ex_alu_result;
                wdata_q      <= st_wdata;
                wstrb_q      <= st_wstrb;
                funct3_q     <= ex_funct3;
                we_q         <= ex_mem_wr_en;
                load_q       <= ex_mem_rd_en;
                rd_q         <= ex_rd;
                reg_wr_en_q  <= ex_reg_wr_en;
                mem_to_reg_q <= ex_mem_to_reg;
                wb_sel_q     <= ex_wb_sel;
            end
            if (state_q == WAIT && dmem_rsp_valid)
                rdata_q <= dmem_rdata;
        end
    end

    // NOTE: defaults come first so every path assigns every signal and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        stall     = 1'b0;
        exc       = 1'b0;
        case (state_q)
            IDLE: begin
                exc = misaligned;
                if (start) begin
                    stall   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                req_valid = 1'b1;
                stall     = 1'b1;
                if (dmem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (dmem_rsp_valid) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    load_aligner u_load_aligner (
        .rdata    (rdata_q),
        .addr     (addr_q[1:0]),
        .funct3   (funct3_q),
        .mem_data (ext_data)
    );

    // Outside IDLE the writeback fields come from the latched copy of the memory op.
    always_comb begin
        if (state_q == IDLE) begin
            alu_result = ex_alu_result;
            rd         = ex_rd;
            mem_to_reg = ex_mem_to_reg;
            wb_sel     = ex_wb_sel;
            mem_data   = '0;
            reg_wr_en  = ex_valid & ex_reg_wr_en & ~misaligned & ~rst;
        end else begin
            alu_result = addr_q;
            rd         = rd_q;
            mem_to_reg = mem_to_reg_q;
            wb_sel     = wb_sel_q;
            mem_data   = load_q ? ext_data : '0;
            reg_wr_en  = reg_wr_en_q & ~rst;
        end
    end

    assign dmem_req_valid = req_valid & ~rst;
    assign dmem_addr      = {addr_q[WIDTH-1:2], 2'b00};
    assign dmem_we        = dmem_req_valid & we_q;
    assign dmem_wstrb     = dmem_req_valid ? wstrb_q : 4'b0000;
    assign dmem_wdata     = wdata_q;
    assign mem_stall      = stall & ~rst;
    assign misalign_exc   = exc & ~rst;

endmodule
